// File: rtl/brainfuck_core_if.sv
// ---------------------------------------------------------------------------
// brainfuck_core_if
//   Bus bundle between the brainfuck core and its surroundings. It carries the
//   code ROM port, the data RAM port and the character I/O strobes.
//
//   Parameters:
//     ARRAY_ADDR_WIDTH  width of the data-array address
//     CODE_ADDR_WIDTH   width of the code (program counter) address
//
//   Signals (direction as seen from the core, modport master):
//     code_out       in   instruction byte, valid one cycle after addr_code
//     addr_code      out  program counter to the code ROM
//     done           out  program finished
//     data_in        in   current cell value, valid one cycle after addr_array
//     addr_array     out  data pointer to the data RAM
//     dataOut_array  out  value to write to the current cell
//     write_rq       out  RAM write strobe
//     receivingChar  in   input byte valid strobe
//     receivedChar   in   input byte
//     sendingChar    out  output byte valid strobe
//     sendedChar     out  output byte
//
//   Modport slave is the ROM/RAM/IO side of the same bundle.
// ---------------------------------------------------------------------------
interface brainfuck_core_if #(
    parameter int ARRAY_ADDR_WIDTH = 9,
    parameter int CODE_ADDR_WIDTH  = 9
);
    logic [7:0]                  code_out;
    logic [CODE_ADDR_WIDTH-1:0]  addr_code;
    logic                        done;
    logic [7:0]                  data_in;
    logic [ARRAY_ADDR_WIDTH-1:0] addr_array;
    logic [7:0]                  dataOut_array;
    logic                        write_rq;
    logic                        receivingChar;
    logic [7:0]                  receivedChar;
    logic                        sendingChar;
    logic [7:0]                  sendedChar;

    modport master (
        input  code_out,
        output addr_code,
        output done,
        input  data_in,
        output addr_array,
        output dataOut_array,
        output write_rq,
        input  receivingChar,
        input  receivedChar,
        output sendingChar,
        output sendedChar
    );

    modport slave (
        output code_out,
        input  addr_code,
        input  done,
        output data_in,
        input  addr_array,
        input  dataOut_array,
        input  write_rq,
        output receivingChar,
        output receivedChar,
        input  sendingChar,
        input  sendedChar
    );
endinterface

// File: rtl/brainfuck_core.sv
// ---------------------------------------------------------------------------
// brainfuck_core
//   Brainfuck interpreter core driving a synchronous code ROM and data RAM.
//   Every instruction takes a FETCH cycle (pc presented to the ROM, ptr to the
//   RAM) followed by one EXEC or scan cycle in which the fetched byte and the
//   current cell value are both valid. Loop skipping walks the program one
//   instruction per FETCH+scan pair, tracking bracket nesting in a depth
//   counter.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    brainfuck_core_if.master (code ROM, data RAM, char I/O, done)
//     probe  [3:0] current state encoding, only when BRAINFUCK_CORE_PROBE_EN
//            is defined (FETCH=0 EXEC=1 SCAN_FWD=2 SCAN_BACK=3 WAIT_IN=4
//            DONE=5)
//
//   Optional feature macro: BRAINFUCK_CORE_PROBE_EN
// ---------------------------------------------------------------------------
module brainfuck_core #(
    parameter int ARRAY_ADDR_WIDTH = 9,
    parameter int CODE_ADDR_WIDTH  = 9
) (
    input  logic             clk,
    input  logic             reset,
    brainfuck_core_if.master bus
`ifdef BRAINFUCK_CORE_PROBE_EN
    ,
    output logic [3:0]       probe
`endif
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        EXEC      = 3'd1,
        SCAN_FWD  = 3'd2,
        SCAN_BACK = 3'd3,
        WAIT_IN   = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [7:0] OP_INC   = 8'h2B; // '+'
    localparam logic [7:0] OP_DEC   = 8'h2D; // '-'
    localparam logic [7:0] OP_RIGHT = 8'h3E; // '>'
    localparam logic [7:0] OP_LEFT  = 8'h3C; // '<'
    localparam logic [7:0] OP_OUT   = 8'h2E; // '.'
    localparam logic [7:0] OP_IN    = 8'h2C; // ','
    localparam logic [7:0] OP_LOOP  = 8'h5B; // '['
    localparam logic [7:0] OP_END   = 8'h5D; // ']'
    localparam logic [7:0] OP_HALT  = 8'h00;

    localparam logic [CODE_ADDR_WIDTH-1:0]  PC_ONE  = CODE_ADDR_WIDTH'(1);
    localparam logic [ARRAY_ADDR_WIDTH-1:0] PTR_ONE = ARRAY_ADDR_WIDTH'(1);

    state_t                      state_q, state_d;
    logic [CODE_ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ARRAY_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CODE_ADDR_WIDTH-1:0]  depth_q, depth_d;
    // Scan direction; only meaningful while depth_q != 0.
    logic                        back_q, back_d;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       send_en;
    logic [7:0] send_char;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            back_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            back_q  <= back_d;
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statements leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        depth_d   = depth_q;
        back_d    = back_q;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        send_en   = 1'b0;
        send_char = 8'h00;

        case (state_q)
            FETCH: begin
                // A non-zero depth means a bracket search is in progress.
                if (depth_q != '0) begin
                    state_d = back_q ? SCAN_BACK : SCAN_FWD;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + PC_ONE;
                case (bus.code_out)
                    OP_INC: begin
                        wr_en   = 1'b1;
                        wr_data = bus.data_in + 8'd1;
                    end
                    OP_DEC: begin
                        wr_en   = 1'b1;
                        wr_data = bus.data_in - 8'd1;
                    end
                    OP_RIGHT: ptr_d = ptr_q + PTR_ONE;
                    OP_LEFT:  ptr_d = ptr_q - PTR_ONE;
                    OP_OUT: begin
                        send_en   = 1'b1;
                        send_char = bus.data_in;
                    end
                    OP_IN: begin
                        // pc advances only once the byte has been written.
                        pc_d    = pc_q;
                        state_d = WAIT_IN;
                    end
                    OP_LOOP: begin
                        if (bus.data_in == 8'h00) begin
                            depth_d = PC_ONE;
                            back_d  = 1'b0;
                        end
                    end
                    OP_END: begin
                        if (bus.data_in != 8'h00) begin
                            depth_d = PC_ONE;
                            back_d  = 1'b1;
                            pc_d    = pc_q - PC_ONE;
                        end
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = DONE;
                    end
                    default: ;
                endcase
            end

            SCAN_FWD: begin
                state_d = FETCH;
                pc_d    = pc_q + PC_ONE;
                case (bus.code_out)
                    OP_LOOP: depth_d = depth_q + PC_ONE;
                    // Reaching depth 0 here lands pc just past the matching ']'.
                    OP_END:  depth_d = depth_q - PC_ONE;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = DONE;
                    end
                    default: ;
                endcase
            end

            SCAN_BACK: begin
                state_d = FETCH;
                pc_d    = pc_q - PC_ONE;
                case (bus.code_out)
                    OP_END: depth_d = depth_q + PC_ONE;
                    OP_LOOP: begin
                        depth_d = depth_q - PC_ONE;
                        // Matching '[' found: resume at the instruction after it.
                        if (depth_q == PC_ONE) begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = DONE;
                    end
                    default: ;
                endcase
            end

            WAIT_IN: begin
                if (bus.receivingChar) begin
                    wr_en   = 1'b1;
                    wr_data = bus.receivedChar;
                    pc_d    = pc_q + PC_ONE;
                    state_d = FETCH;
                end
            end

            DONE: ;

            default: state_d = FETCH;
        endcase
    end

    assign bus.addr_code     = pc_q;
    assign bus.addr_array    = ptr_q;
    assign bus.done          = (state_q == DONE);
    assign bus.write_rq      = wr_en;
    assign bus.dataOut_array = wr_data;
    assign bus.sendingChar   = send_en;
    assign bus.sendedChar    = send_char;

`ifdef BRAINFUCK_CORE_PROBE_EN
    assign probe = {1'b0, state_q};
`endif

endmodule

// File: tb/tb_brainfuck_core.sv
// ---------------------------------------------------------------------------
// tb_brainfuck_core
//   Self-checking bench for brainfuck_core. A table of programs with
//   hand-computed results (output count, last output byte, write count,
//   pointer at output) is run on a 9/9-bit core with behavioural ROM/RAM
//   models, followed by hand-written sequences for the input stall and for a
//   reset during a forward scan. A second core with a 5-bit data address runs
//   "<." to observe pointer wrap-around.
// ---------------------------------------------------------------------------
module tb_brainfuck_core;

    localparam int AW      = 9;
    localparam int CW      = 9;
    localparam int BUDGET  = 5000;

    logic clk;
    logic reset;

    brainfuck_core_if #(.ARRAY_ADDR_WIDTH(AW), .CODE_ADDR_WIDTH(CW)) bus ();
    brainfuck_core_if #(.ARRAY_ADDR_WIDTH(5),  .CODE_ADDR_WIDTH(CW)) bus5 ();

`ifdef BRAINFUCK_CORE_PROBE_EN
    logic [3:0] probe;
    logic [3:0] probe5;
`endif

    brainfuck_core #(.ARRAY_ADDR_WIDTH(AW), .CODE_ADDR_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BRAINFUCK_CORE_PROBE_EN
        ,
        .probe (probe)
`endif
    );

    brainfuck_core #(.ARRAY_ADDR_WIDTH(5), .CODE_ADDR_WIDTH(CW)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
`ifdef BRAINFUCK_CORE_PROBE_EN
        ,
        .probe (probe5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory models for the main core ----------------
    logic [7:0] code_mem [0:(1<<CW)-1];
    logic [7:0] ram      [0:(1<<AW)-1];

    always @(posedge clk) bus.code_out <= code_mem[bus.addr_code];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= 8'h00;
        end else if (bus.write_rq) begin
            ram[bus.addr_array] <= bus.dataOut_array;
        end
        bus.data_in <= ram[bus.addr_array];
    end

    // ---------------- fixed "<." program for the 5-bit core ----------------
    always @(posedge clk) begin
        bus5.code_out <= (bus5.addr_code == 9'd0) ? 8'h3C :
                         (bus5.addr_code == 9'd1) ? 8'h2E : 8'h00;
        bus5.data_in  <= 8'h00;
    end
    assign bus5.receivingChar = 1'b0;
    assign bus5.receivedChar  = 8'h00;

    // ---------------- output monitor ----------------
    int         send_cnt;
    int         write_cnt;
    logic [7:0] last_char;
    logic [8:0] last_addr;
    logic       s5_seen;
    logic [4:0] s5_addr;

    always @(negedge clk) begin
        if (reset) begin
            send_cnt  = 0;
            write_cnt = 0;
            last_char = 8'h00;
            last_addr = 9'd0;
            s5_seen   = 1'b0;
            s5_addr   = 5'd0;
        end else begin
            if (bus.sendingChar) begin
                send_cnt++;
                last_char = bus.sendedChar;
                last_addr = bus.addr_array;
            end
            if (bus.write_rq) write_cnt++;
            if (bus5.sendingChar) begin
                s5_seen = 1'b1;
                s5_addr = bus5.addr_array;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      prog;
        int         exp_sends;
        logic [7:0] exp_char;
        int         exp_writes;
        logic [8:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string p, input int s, input logic [7:0] c,
                           input int w, input logic [8:0] a);
        vec_t v;
        v.prog       = p;
        v.exp_sends  = s;
        v.exp_char   = c;
        v.exp_writes = w;
        v.exp_addr   = a;
        vecs.push_back(v);
    endtask

    task automatic load_prog(input string p);
        for (int i = 0; i < (1<<CW); i++) code_mem[i] = 8'h00;
        for (int i = 0; i < p.len(); i++) code_mem[i] = p[i];
    endtask

    // Reset the core, load a program and release reset just after a rising edge.
    task automatic start_prog(input string p);
        @(posedge clk); #1;
        reset = 1'b1;
        load_prog(p);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!bus.done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " done"}, {31'd0, bus.done}, 32'd1);
    endtask

    logic stall_ok;

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.receivingChar = 1'b0;
        bus.receivedChar  = 8'h00;
        load_prog("");

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst addr_code",     32'(bus.addr_code),     32'd0);
        check("rst addr_array",    32'(bus.addr_array),    32'd0);
        check("rst done",          32'(bus.done),          32'd0);
        check("rst write_rq",      32'(bus.write_rq),      32'd0);
        check("rst sendingChar",   32'(bus.sendingChar),   32'd0);
        check("rst sendedChar",    32'(bus.sendedChar),    32'd0);
        check("rst dataOut_array", 32'(bus.dataOut_array), 32'd0);

        // prog, sends, last char, writes, ptr at last send
        add_vec("++>+++[<+>-]<.",  1, 8'h05, 11, 9'd0);
        add_vec("-.",              1, 8'hFF,  1, 9'd0);
        add_vec("[+[+]+]+.",       1, 8'h01,  1, 9'd0);
        add_vec("+++.--.",         2, 8'h01,  5, 9'd0);
        add_vec(">>>-<<<.",        1, 8'h00,  1, 9'd0);
        add_vec("+[-].",           1, 8'h00,  2, 9'd0);
        add_vec("++[>+++<-]>.",    1, 8'h06, 10, 9'd1);
        add_vec("<-.",             1, 8'hFF,  1, 9'd511);
        add_vec("++[>[-]+<-]>.",   1, 8'h01,  7, 9'd1);
        add_vec("x+ +.",           1, 8'h02,  2, 9'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            start_prog(vecs[k].prog);
            wait_done(vecs[k].prog);
            @(negedge clk);
            check({vecs[k].prog, " sends"},  32'(send_cnt),  32'(vecs[k].exp_sends));
            check({vecs[k].prog, " char"},   32'(last_char), 32'(vecs[k].exp_char));
            check({vecs[k].prog, " writes"}, 32'(write_cnt), 32'(vecs[k].exp_writes));
            check({vecs[k].prog, " ptr"},    32'(last_addr), 32'(vecs[k].exp_addr));
            check({vecs[k].prog, " write_rq in DONE"}, 32'(bus.write_rq), 32'd0);
        end

        // 5-bit data pointer wraps to 31 on '<' (second core ran alongside).
        check("w5 sent",  32'(s5_seen), 32'd1);
        check("w5 ptr",   32'(s5_addr), 32'd31);
        check("w5 done",  32'(bus5.done), 32'd1);

        // Input stall: core waits in WAIT_IN at pc 0 until receivingChar.
        start_prog(",.");
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.addr_code != 9'd0 || bus.write_rq || bus.sendingChar || bus.done)
                stall_ok = 1'b0;
        end
        check("in stall", 32'(stall_ok), 32'd1);
        bus.receivingChar = 1'b1;
        bus.receivedChar  = 8'h41;
        #1;
        check("in write_rq", 32'(bus.write_rq),      32'd1);
        check("in data",     32'(bus.dataOut_array), 32'h41);
        @(posedge clk); #1;
        bus.receivingChar = 1'b0;
        bus.receivedChar  = 8'h00;
        wait_done("in");
        @(negedge clk);
        check("in sends",  32'(send_cnt),  32'd1);
        check("in char",   32'(last_char), 32'h41);
        check("in writes", 32'(write_cnt), 32'd1);

        // Reset during a forward scan of "[+[+]+]+.".
        start_prog("[+[+]+]+.");
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scan pc before reset", 32'(bus.addr_code), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("scan rst addr_code",   32'(bus.addr_code),   32'd0);
        check("scan rst addr_array",  32'(bus.addr_array),  32'd0);
        check("scan rst outputs",
              {26'd0, bus.done, bus.write_rq, bus.sendingChar,
               |bus.sendedChar, |bus.dataOut_array, 1'b0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("scan restart pc", 32'(bus.addr_code), 32'd0);
        wait_done("scan rerun");
        @(negedge clk);
        check("scan rerun sends", 32'(send_cnt),  32'd1);
        check("scan rerun char",  32'(last_char), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/brainfuck_core.md
BRAINFUCK_CORE -- requirements
Module: brainfuck_core

Interface
REQ-001 SHALL have parameter ARRAY_ADDR_WIDTH, default 9: width of the data-array address (first positional parameter).
REQ-002 SHALL have parameter CODE_ADDR_WIDTH, default 9: width of the code address (second positional parameter).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port code_out, input, 8: instruction byte from the code ROM, valid one cycle after addr_code.
REQ-006 SHALL have port addr_code, output, CODE_ADDR_WIDTH: program counter (pc) driven to the code ROM.
REQ-007 SHALL have port done, output, 1: program finished.
REQ-008 SHALL have port data_in, input, 8: current cell value from the data RAM, valid one cycle after addr_array.
REQ-009 SHALL have port addr_array, output, ARRAY_ADDR_WIDTH: data pointer (ptr).
REQ-010 SHALL have port dataOut_array, output, 8: value to write to the cell.
REQ-011 SHALL have port write_rq, output, 1: RAM write strobe.
REQ-012 SHALL have port receivingChar, input, 1: input byte valid strobe.
REQ-013 SHALL have port receivedChar, input, 8: input byte.
REQ-014 SHALL have port sendingChar, output, 1: output byte valid strobe.
REQ-015 SHALL have port sendedChar, output, 8: output byte.

Function
REQ-016 SHALL run states FETCH, EXEC, SCAN_FWD, SCAN_BACK, WAIT_IN and DONE; each instruction SHALL take FETCH (1 cycle) followed by EXEC or a scan cycle.
REQ-017 In EXEC, '+' and '-' SHALL drive dataOut_array = data_in ±1 (mod 256), assert write_rq for exactly 1 cycle, and set pc+1.
REQ-018 In EXEC, '>' and '<' SHALL set ptr ±1, wrapping mod 2^ARRAY_ADDR_WIDTH, and set pc+1.
REQ-019 In EXEC, '.' SHALL assert sendingChar for exactly 1 cycle with sendedChar = data_in, and set pc+1.
REQ-020 On ',' the core SHALL enter WAIT_IN; on the first cycle with receivingChar=1 it SHALL write receivedChar (write_rq for 1 cycle), set pc+1 and return to FETCH.
REQ-021 On '[' with data_in==0 the core SHALL set depth=1, pc+1 and enter SCAN_FWD; otherwise it SHALL set pc+1.
REQ-022 In SCAN_FWD, each fetched '[' SHALL increment depth and each ']' SHALL decrement it; when depth reaches 0 the core SHALL set pc+1 and resume FETCH/EXEC; pc SHALL advance by 1 per scanned instruction (FETCH+scan = 2 cycles).
REQ-023 On ']' with data_in!=0 the core SHALL set depth=1, pc-1 and enter SCAN_BACK; ']' SHALL increment depth, '[' SHALL decrement it, pc SHALL step -1; at depth 0 the core SHALL set pc+1 (the instruction after the matching '[').
REQ-024 The depth counter SHALL be CODE_ADDR_WIDTH bits wide.
REQ-025 Byte 0x00 in EXEC or in either scan SHALL enter DONE; in DONE done=1, write_rq=0, sendingChar=0, and the core SHALL hold until reset.
REQ-026 All other bytes SHALL be NOPs (pc+1); pc SHALL wrap mod 2^CODE_ADDR_WIDTH.
REQ-027 write_rq SHALL be 0 except in the cycles specified above; dataOut_array is a don't-care when write_rq=0.

Reset
REQ-028 While reset=1: pc=0, ptr=0, depth=0, state=FETCH, done=0, write_rq=0, sendingChar=0, sendedChar=0, dataOut_array=0.
REQ-029 Asserting reset mid-instruction, mid-scan or in WAIT_IN SHALL abort immediately; the first FETCH after deassertion SHALL be at pc=0; RAM contents are not cleared by the core.

Configuration
REQ-030 With macro BRAINFUCK_CORE_PROBE_EN defined, the core SHALL add output probe[3:0] carrying the state encoding (FETCH=0, EXEC=1, SCAN_FWD=2, SCAN_BACK=3, WAIT_IN=4, DONE=5); without the macro the port SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-031 Program "++>+++[<+>-]<." then 0x00 -> exactly one sendingChar pulse with sendedChar=0x05, then done=1.
REQ-032 Program "-." from a zero cell -> sendedChar=0xFF (wrap).
REQ-033 Program "[+[+]+]+." from a zero cell -> nested loop skipped; sendedChar=0x01.
REQ-034 Program ",." with receivingChar held 0 for 10 cycles, then a 1-cycle pulse with receivedChar=0x41 -> core stalls in WAIT_IN, then sendedChar=0x41.
REQ-035 Program "<." with ARRAY_ADDR_WIDTH=5 -> addr_array=31 during '.'.
REQ-036 Reset asserted during a SCAN_FWD -> all outputs at reset values; restart at addr_code=0.
